// File: rtl/dtm_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dtm_pkg
// Purpose : Shared types and constants for the RISC-V debug transport regs.
// Rev     : 1.0
// ============================================================================
package dtm_pkg;

   typedef enum logic [1:0] {
      NOP   = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2
   } dmi_op_t;

   // Status codes share the op field of the dmi register.
   localparam logic [1:0] OK     = 2'd0;
   localparam logic [1:0] FAILED = 2'd2;
   localparam logic [1:0] BUSY   = 2'd3;

   localparam logic [5:0] DTMCS_IR    = 6'h10;
   localparam logic [5:0] DMI_IR      = 6'h11;
   localparam logic [3:0] DTM_VERSION = 4'd1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RSP  = 2'd2
   } dmi_fsm_t;

endpackage
`default_nettype wire

// File: rtl/dtm_dr_shift.sv
`default_nettype none
// ============================================================================
// Module  : dtm_dr_shift
// Purpose : JTAG data register with parallel capture and LSB-first shift.
// Rev     : 1.0
// ============================================================================
module dtm_dr_shift #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             capture,
   input  logic             shift,
   input  logic [WIDTH-1:0] capture_value,
   input  logic             tdi,
   output logic [WIDTH-1:0] value
);

   always_ff @(posedge clk) begin
      if (rst)
         value <= '0;
      else if (capture)
         value <= capture_value;
      else if (shift)
         value <= {tdi, value[WIDTH-1:1]};
   end

endmodule
`default_nettype wire

// File: rtl/dtm_dmi_regs.sv
`default_nettype none
// ============================================================================
// Module  : dtm_dmi_regs
// Purpose : dtmcs/dmi data registers and the DMI request/response bridge.
// Rev     : 1.0
// ============================================================================
module dtm_dmi_regs
   import dtm_pkg::*;
#(
   parameter int ABITS     = 7,
   parameter int IDLE_HINT = 1
) (
   input  logic             tclk,
   input  logic             trst,
   input  logic             tdi,
   input  logic             capture_dr,
   input  logic             shift_dr,
   input  logic             update_dr,
   input  logic             sel_dtmcs,
   input  logic             sel_dmi,
   output logic             tdo_dr,
   output logic             dmi_req_valid,
   input  logic             dmi_req_ready,
   output logic [ABITS-1:0] dmi_req_addr,
   output logic [31:0]      dmi_req_data,
   output logic [1:0]       dmi_req_op,
   input  logic             dmi_rsp_valid,
   output logic             dmi_rsp_ready,
   input  logic [31:0]      dmi_rsp_data,
   input  logic [1:0]       dmi_rsp_op
);

   localparam int DMI_W = ABITS + 34;

   logic             dtmcs_sel, dmi_sel;
   logic [31:0]      dtmcs_q, dtmcs_cap;
   logic [DMI_W-1:0] dmi_q, dmi_cap;
   logic [1:0]       cap_op, upd_op, sticky;
   logic             dtmcs_upd, dmi_upd, dmi_capt, hard_reset, dmi_reset, upd_req;
   logic             discard, dtmcs_unused;
   dmi_fsm_t         state;
   logic [ABITS-1:0] result_addr;
   logic [31:0]      result_data;

   // Strobes only count when exactly one register is selected.
   assign dtmcs_sel = sel_dtmcs & ~sel_dmi;
   assign dmi_sel   = sel_dmi & ~sel_dtmcs;

   always_comb begin
      if (sticky != OK)
         cap_op = sticky;
      else if (state != IDLE)
         cap_op = BUSY;
      else
         cap_op = OK;
   end

   assign dtmcs_cap = {14'b0, 1'b0, 1'b0, 1'b0, 3'(IDLE_HINT), sticky, 6'(ABITS), DTM_VERSION};
   assign dmi_cap   = {result_addr, result_data, cap_op};

   dtm_dr_shift #(.WIDTH(32)) u_dtmcs (
      .clk(tclk), .rst(trst),
      .capture(capture_dr & dtmcs_sel), .shift(shift_dr & dtmcs_sel),
      .capture_value(dtmcs_cap), .tdi(tdi), .value(dtmcs_q)
   );

   dtm_dr_shift #(.WIDTH(DMI_W)) u_dmi (
      .clk(tclk), .rst(trst),
      .capture(capture_dr & dmi_sel), .shift(shift_dr & dmi_sel),
      .capture_value(dmi_cap), .tdi(tdi), .value(dmi_q)
   );

   assign tdo_dr = dtmcs_sel ? dtmcs_q[0] : (dmi_sel ? dmi_q[0] : 1'b0);

   assign dtmcs_upd    = update_dr & dtmcs_sel;
   assign dmi_upd      = update_dr & dmi_sel;
   assign dmi_capt     = capture_dr & dmi_sel;
   assign hard_reset   = dtmcs_upd & dtmcs_q[17];
   assign dmi_reset    = dtmcs_upd & dtmcs_q[16];
   assign upd_op       = dmi_q[1:0];
   assign upd_req      = dmi_upd & ((upd_op == READ) | (upd_op == WRITE));
   assign dtmcs_unused = ^{dtmcs_q[31:18], dtmcs_q[15:0]};

   // Later assignments win: flag updates first, FSM progress after.
   always_ff @(posedge tclk) begin
      if (trst) begin
         state         <= IDLE;
         dmi_req_valid <= 1'b0;
         dmi_rsp_ready <= 1'b0;
         dmi_req_addr  <= '0;
         dmi_req_data  <= '0;
         dmi_req_op    <= '0;
         sticky        <= OK;
         discard       <= 1'b0;
         result_addr   <= '0;
         result_data   <= '0;
      end else if (hard_reset) begin
         // A response already owed by the DM is swallowed once it arrives.
         state         <= IDLE;
         dmi_req_valid <= 1'b0;
         sticky        <= OK;
         discard       <= (state == RSP) | (discard & ~dmi_rsp_valid);
         dmi_rsp_ready <= (state == RSP) | (discard & ~dmi_rsp_valid);
      end else begin
         if (dmi_reset)
            sticky <= OK;
         if (dmi_capt && sticky == OK && state != IDLE)
            sticky <= BUSY;
         if (upd_req && sticky == OK) begin
            if (state != IDLE) begin
               sticky <= BUSY;
            end else begin
               dmi_req_addr  <= dmi_q[DMI_W-1:34];
               dmi_req_data  <= dmi_q[33:2];
               dmi_req_op    <= upd_op;
               result_addr   <= dmi_q[DMI_W-1:34];
               dmi_req_valid <= 1'b1;
               state         <= REQ;
            end
         end
         if (discard && dmi_rsp_valid) begin
            discard <= 1'b0;
            if (state != RSP)
               dmi_rsp_ready <= 1'b0;
         end
         case (state)
            REQ: begin
               if (dmi_req_ready) begin
                  dmi_req_valid <= 1'b0;
                  dmi_rsp_ready <= 1'b1;
                  state         <= RSP;
               end
            end
            RSP: begin
               if (dmi_rsp_valid && !discard) begin
                  dmi_rsp_ready <= 1'b0;
                  state         <= IDLE;
                  if (dmi_req_op == READ)
                     result_data <= dmi_rsp_data;
                  if (dmi_rsp_op == FAILED)
                     sticky <= FAILED;
                  else if (dmi_rsp_op == BUSY && sticky == OK)
                     sticky <= BUSY;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dtm_dmi_regs.sv
`default_nettype none
// ============================================================================
// Module  : tb_dtm_dmi_regs
// Purpose : Directed plus randomized bench for dtm_dmi_regs with a scan-level model.
// Rev     : 1.0
// ============================================================================
module tb_dtm_dmi_regs;

   localparam int ABITS = 7;
   localparam int DW    = ABITS + 34;

   logic             tclk = 1'b0;
   logic             trst, tdi, capture_dr, shift_dr, update_dr, sel_dtmcs, sel_dmi, tdo_dr;
   logic             dmi_req_valid, dmi_req_ready;
   logic [ABITS-1:0] dmi_req_addr;
   logic [31:0]      dmi_req_data;
   logic [1:0]       dmi_req_op;
   logic             dmi_rsp_valid, dmi_rsp_ready;
   logic [31:0]      dmi_rsp_data;
   logic [1:0]       dmi_rsp_op;

   int          tests = 0;
   int          fails = 0;
   int          m_sticky, m_raddr;
   logic [31:0] m_rdata;

   always #5 tclk = ~tclk;

   dtm_dmi_regs #(.ABITS(ABITS), .IDLE_HINT(1)) dut (
      .tclk(tclk), .trst(trst), .tdi(tdi),
      .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
      .sel_dtmcs(sel_dtmcs), .sel_dmi(sel_dmi), .tdo_dr(tdo_dr),
      .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
      .dmi_req_addr(dmi_req_addr), .dmi_req_data(dmi_req_data), .dmi_req_op(dmi_req_op),
      .dmi_rsp_valid(dmi_rsp_valid), .dmi_rsp_ready(dmi_rsp_ready),
      .dmi_rsp_data(dmi_rsp_data), .dmi_rsp_op(dmi_rsp_op)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] exp_dtmcs();
      return 64'((1 << 12) + m_sticky * 1024 + ABITS * 16 + 1);
   endfunction

   function automatic logic [63:0] exp_dmi(input int op);
      return (64'(m_raddr) << 34) | (64'(m_rdata) << 2) | 64'(op);
   endfunction

   function automatic logic [63:0] req_vec(input int addr, input logic [31:0] data, input int op);
      return (64'(1) << 41) | (64'(addr) << 34) | (64'(data) << 2) | 64'(op);
   endfunction

   // Full capture/shift/(update) sequence; returns at the negedge after the update edge.
   task automatic scan(input bit dmi, input int n, input logic [63:0] din, input bit do_upd,
                       output logic [63:0] dout);
      @(negedge tclk);
      sel_dtmcs = !dmi; sel_dmi = dmi; capture_dr = 1'b1;
      @(negedge tclk);
      capture_dr = 1'b0; shift_dr = 1'b1;
      dout = '0;
      for (int i = 0; i < n; i++) begin
         tdi = din[i];
         dout[i] = tdo_dr;
         @(negedge tclk);
      end
      shift_dr = 1'b0; update_dr = do_upd;
      @(negedge tclk);
      update_dr = 1'b0;
   endtask

   task automatic dtmcs_scan(input logic [31:0] din);
      logic [63:0] dout;
      scan(1'b0, 32, 64'(din), 1'b1, dout);
      chk("dtmcs_capture", dout, exp_dtmcs());
      if (din[16] || din[17]) m_sticky = 0;
   endtask

   task automatic dmi_txn(input int addr, input logic [31:0] data, input int op, input int delay,
                          input logic [31:0] rdata, input int rop, input bit busy_probe);
      logic [63:0] dout, rv;
      rv = req_vec(addr, data, op);
      scan(1'b1, DW, (64'(addr) << 34) | (64'(data) << 2) | 64'(op), 1'b1, dout);
      chk("dmi_capture", dout, exp_dmi(m_sticky));
      if (!((op == 1 || op == 2) && m_sticky == 0)) begin
         chk("no_request", 64'(dmi_req_valid), 64'(0));
         return;
      end
      m_raddr = addr;
      chk("req_issue", {dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op}, rv);
      for (int k = 0; k < delay; k++) begin
         @(negedge tclk);
         chk("req_hold", {dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op}, rv);
      end
      dmi_req_ready = 1'b1;
      @(negedge tclk);
      dmi_req_ready = 1'b0;
      chk("req_accept", {dmi_req_valid, dmi_rsp_ready}, 64'b01);
      if (busy_probe) begin
         scan(1'b1, DW, 64'(0), 1'b0, dout);
         chk("busy_capture", dout, exp_dmi(3));
         if (m_sticky == 0) m_sticky = 3;
      end
      dmi_rsp_valid = 1'b1; dmi_rsp_data = rdata; dmi_rsp_op = 2'(rop);
      @(negedge tclk);
      dmi_rsp_valid = 1'b0;
      chk("rsp_done", 64'(dmi_rsp_ready), 64'(0));
      if (op == 1) m_rdata = rdata;
      if (rop == 2) m_sticky = 2;
      else if (rop == 3 && m_sticky == 0) m_sticky = 3;
   endtask

   initial begin
      logic [63:0] dout;
      int addr, op, r;
      trst = 1'b1; tdi = 1'b0; capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
      sel_dtmcs = 1'b0; sel_dmi = 1'b0; dmi_req_ready = 1'b0; dmi_rsp_valid = 1'b0;
      dmi_rsp_data = '0; dmi_rsp_op = '0;
      m_sticky = 0; m_raddr = 0; m_rdata = '0;

      repeat (2) @(negedge tclk);
      chk("reset_outputs", {dmi_req_valid, dmi_rsp_ready, tdo_dr, dmi_req_addr, dmi_req_data, dmi_req_op}, 64'(0));
      trst = 1'b0;

      dtmcs_scan(32'h0);
      chk("dtmcs_literal", exp_dtmcs(), 64'h1071);

      dmi_txn(32'h10, 32'h1, 2, 0, 32'h0, 0, 1'b0);
      dmi_txn(32'h10, 32'h0, 1, 5, 32'hDEADBEEF, 0, 1'b0);
      scan(1'b1, DW, 64'(0), 1'b0, dout);
      chk("read_result", dout, (64'h10 << 34) | (64'hDEADBEEF << 2));

      dmi_txn(32'h22, 32'h55, 2, 1, 32'h0, 0, 1'b1);
      dtmcs_scan(32'h0);
      dmi_txn(32'h33, 32'h0, 1, 0, 32'h0, 0, 1'b0);
      dtmcs_scan(32'h0001_0000);
      dtmcs_scan(32'h0);
      dmi_txn(32'h44, 32'h1234, 2, 0, 32'h0, 0, 1'b0);

      dmi_txn(32'h05, 32'h0, 1, 0, 32'hCAFE_F00D, 2, 1'b0);
      dtmcs_scan(32'h0);
      dmi_txn(32'h06, 32'h7, 2, 0, 32'h0, 0, 1'b0);
      dmi_txn(32'h07, 32'h0, 1, 0, 32'h0, 0, 1'b0);
      dtmcs_scan(32'h0);
      dtmcs_scan(32'h0001_0000);

      // dmihardreset while a request is still waiting for ready.
      scan(1'b1, DW, (64'h5A << 34) | (64'h99 << 2) | 64'd2, 1'b1, dout);
      chk("hr_capture", dout, exp_dmi(0));
      m_raddr = 32'h5A;
      chk("hr_req", {dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op}, req_vec(32'h5A, 32'h99, 2));
      dtmcs_scan(32'h0002_0000);
      chk("hr_drop", {dmi_req_valid, dmi_rsp_ready}, 64'b00);
      scan(1'b1, DW, 64'(0), 1'b0, dout);
      chk("hr_idle", dout, exp_dmi(0));

      for (int it = 0; it < 12; it++) begin
         addr = int'($urandom_range(0, 127));
         op   = int'($urandom_range(0, 3));
         r    = int'($urandom_range(0, 4));
         dmi_txn(addr, $urandom, op, int'($urandom_range(0, 3)), $urandom,
                 (r == 3) ? 2 : ((r == 4) ? 3 : 0), 1'b0);
         if (m_sticky != 0 && $urandom_range(0, 1) == 1) dtmcs_scan(32'h0001_0000);
      end

      // trst in the middle of a shift while a response is outstanding.
      dtmcs_scan(32'h0001_0000);
      scan(1'b1, DW, (64'h3C << 34) | 64'd1, 1'b1, dout);
      chk("tr_capture", dout, exp_dmi(0));
      dmi_req_ready = 1'b1;
      @(negedge tclk);
      dmi_req_ready = 1'b0;
      chk("tr_in_rsp", 64'(dmi_rsp_ready), 64'(1));
      sel_dtmcs = 1'b0; sel_dmi = 1'b1; capture_dr = 1'b1;
      @(negedge tclk);
      capture_dr = 1'b0; shift_dr = 1'b1; tdi = 1'b1;
      repeat (4) @(negedge tclk);
      trst = 1'b1;
      @(negedge tclk);
      trst = 1'b0; shift_dr = 1'b0;
      chk("tr_outputs", {dmi_req_valid, dmi_rsp_ready, tdo_dr, dmi_req_addr, dmi_req_data, dmi_req_op}, 64'(0));
      m_sticky = 0; m_raddr = 0; m_rdata = '0;
      dtmcs_scan(32'h0);
      scan(1'b1, DW, 64'(0), 1'b0, dout);
      chk("tr_dmi_clear", dout, 64'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dtm_dmi_regs.md
Name: dtm_dmi_regs

Overview:
- JTAG-side data-register block directly downstream of the TAP controller, clocked by TCK.
- Implements the RISC-V debug-transport registers dtmcs (IR 0x10) and dmi (IR 0x11) as shift registers driven by TAP state strobes.
- Converts each completed dmi scan into a valid/ready request toward the Debug Module and latches the response for the next scan.
- The TAP muxes tdo_dr onto TDO when either register is selected.

Parameters:
ABITS, 7, DMI address width; dmi DR length = ABITS+34
IDLE_HINT, 1, value reported in dtmcs.idle

Ports:
tclk  in  1  TCK; single clock for all state
trst  in  1  synchronous active-high reset
tdi  in  1  serial data from TAP
capture_dr  in  1  TAP in CAPTURE_DR this cycle
shift_dr  in  1  TAP in SHIFT_DR this cycle
update_dr  in  1  TAP in UPDATE_DR this cycle
sel_dtmcs  in  1  active IR == 0x10
sel_dmi  in  1  active IR == 0x11
tdo_dr  out  1  LSB of selected shift register, combinational
dmi_req_valid  out  1  request valid
dmi_req_ready  in  1  DM accepts request
dmi_req_addr  out  ABITS  request address
dmi_req_data  out  32  write data
dmi_req_op  out  2  1 = read, 2 = write
dmi_rsp_valid  in  1  DM response valid
dmi_rsp_ready  out  1  block accepts response
dmi_rsp_data  in  32  read data
dmi_rsp_op  in  2  0 = ok, 2 = failed, 3 = busy

Behaviour:
- Clock and reset: one clock, tclk. Reset trst is synchronous and active-high. While trst is high, every register clears on the next edge.
- Reset values: req_valid=0, rsp_ready=0, FSM=IDLE, sticky=0, result={addr 0, data 0}, shift registers 0, tdo_dr=0.
- Strobe qualification: strobes act only when exactly one of sel_dtmcs/sel_dmi is high; otherwise they are ignored.
- dtmcs capture: shift <= {14'b0, dmihardreset=0, dmireset=0, 1'b0, IDLE_HINT[2:0], sticky[1:0], ABITS[5:0], version=4'd1}.
- dtmcs update:
  - bit16 (dmireset) clears sticky.
  - bit17 (dmihardreset) clears sticky, drops req_valid, forces FSM to IDLE, and sets a discard flag. The discard flag consumes and ignores the next rsp if one was outstanding.
  - All other bits are ignored.
- dmi capture: shift <= {result_addr, result_data, op}.
  - op = sticky if sticky != 0.
  - Otherwise op = 3 if FSM != IDLE; this case also sets sticky=3.
  - Otherwise op = 0.
- Shifting: on shift_dr, shift <= {tdi, shift[N-1:1]} for the selected register (LSB first). tdo_dr = selected shift[0].
- dmi update with op 1 or 2:
  - If sticky != 0: the request is dropped.
  - If FSM != IDLE: the request is dropped and sticky=3.
  - Otherwise: latch addr/data/op onto the req outputs, set result_addr=addr, and go to REQ.
- dmi update with op 0 or 3: no action.
- FSM:
  - IDLE: waits for an accepted update as above.
  - REQ: req_valid=1 and the req outputs stay stable. When req_ready is sampled high, go to RSP (req_valid=0 next cycle).
  - RSP: rsp_ready=1. When rsp_valid is sampled high:
    - result_data <= rsp_data for reads; unchanged for writes.
    - rsp_op 2 sets sticky=2; rsp_op 3 sets sticky=3, but only if sticky is 0.
    - Go to IDLE.
- Minimum latency: update -> req_valid is 1 cycle; req handshake -> rsp_ready is 1 cycle.
- Priority on the same edge: trst > dmihardreset > FSM progress > capture/update flag setting. Capture on the same edge as the RSP completion reports busy, because capture sees the pre-edge FSM state.
- Sticky error is never cleared by any DMI activity, only by dmireset, dmihardreset or trst.

Decomposition:
- Shared package dtm_pkg holds:
  - dmi_op_t (NOP=0, READ=1, WRITE=2, and status codes OK=0, FAILED=2, BUSY=3);
  - DTMCS_IR=6'h10 and DMI_IR=6'h11;
  - DTM_VERSION=4'd1;
  - dmi_fsm_t {IDLE, REQ, RSP}.
- One natural sub-module: dtm_dr_shift, a parameterised capture/shift register with an LSB-first serial port, instantiated once per register.

Test Plan:
- Reset, select dtmcs, capture and shift 32 bits -> shifted-out value 0x00001071 (ABITS=7, IDLE_HINT=1, version 1).
- dmi write: scan addr=0x10, data=0x00000001, op=2, then update -> req_valid the next cycle with addr 0x10, data 0x1, op 2. Then rsp ok -> next capture returns op 0.
- dmi read with dmi_req_ready held low 5 cycles and rsp_data=0xDEADBEEF -> req_valid high for all 5 cycles with stable outputs. The next capture after rsp returns data 0xDEADBEEF, addr 0x10, op 0.
- Capture dmi while in RSP -> op=3, and dtmcs then reads dmistat=3. A following dmi update with op=1 issues no request. After dmireset, dmistat=0 and a new request is issued.
- rsp_op=2 from the DM -> dmistat=2 sticky across two further dmi scans, with no requests issued.
- dmihardreset while in REQ -> req_valid falls the next cycle and the FSM is IDLE. Also assert trst mid-shift -> all outputs return to their reset values on the next edge.
